// File: rtl/jt6295_pkg.sv
// ============================================================================
// Module      : jt6295_pkg
// Description : Shared constants and sequencer state encoding for jt6295_chseq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt6295_pkg;

    localparam int SLOTS    = 4;
    localparam int NIBW     = 4;
    localparam int ROMW_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_t;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jt6295_chseq_regs.sv
// ============================================================================
// Module      : jt6295_chseq_regs
// Description : Four-entry channel register file (cur/last/att/first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt6295_chseq_regs
    import jt6295_pkg::*;
#(
    parameter int ROMW = ROMW_DEF
) (
    input  logic            rst,
    input  logic            clk,
    input  logic [1:0]      idx_i,
    input  logic            load_i,
    input  logic [ROMW-1:0] start_addr_i,
    input  logic [ROMW-1:0] stop_addr_i,
    input  logic [NIBW-1:0] att_i,
    input  logic            inc_i,
    input  logic            clr_first_i,
    output logic [ROMW:0]   cur_o,
    output logic [ROMW-1:0] last_o,
    output logic [NIBW-1:0] att_o,
    output logic            first_o
);

    // cur is a nibble address {byte, half}; half=0 selects the high nibble
    logic [ROMW:0]   cur_q   [SLOTS];
    logic [ROMW-1:0] last_q  [SLOTS];
    logic [NIBW-1:0] att_q   [SLOTS];
    logic [SLOTS-1:0] first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                cur_q[i]  <= '0;
                last_q[i] <= '0;
                att_q[i]  <= '0;
            end
            first_q <= '0;
        end else if (load_i) begin
            cur_q[idx_i]   <= {start_addr_i, 1'b0};
            last_q[idx_i]  <= stop_addr_i;
            att_q[idx_i]   <= att_i;
            first_q[idx_i] <= 1'b1;
        end else begin
            if (inc_i)
                cur_q[idx_i] <= cur_q[idx_i] + (ROMW+1)'(1);
            if (clr_first_i)
                first_q[idx_i] <= 1'b0;
        end
    end

    assign cur_o   = cur_q[idx_i];
    assign last_o  = last_q[idx_i];
    assign att_o   = att_q[idx_i];
    assign first_o = first_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/jt6295_chseq.sv
// ============================================================================
// Module      : jt6295_chseq
// Description : 4-slot time-multiplexed ADPCM channel playback sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt6295_chseq
    import jt6295_pkg::*;
#(
    parameter int ROMW = ROMW_DEF
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen4,
    input  logic [ROMW-1:0] start_addr,
    input  logic [ROMW-1:0] stop_addr,
    input  logic [3:0]      att,
    input  logic [3:0]      start,
    input  logic [3:0]      stop,
    output logic [3:0]      busy,
    output logic [3:0]      ack,
    output logic            zero,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_cs,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok,
    output logic [3:0]      nib,
    output logic [3:0]      nib_att,
    output logic [1:0]      nib_ch,
    output logic            nib_first,
    output logic            nib_valid
);

    seq_state_t      state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0]      busy_q, busy_d;
    logic [3:0]      ack_q, ack_d;
    logic            zero_q, zero_d;
    logic [ROMW-1:0] rom_addr_q, rom_addr_d;
    logic            rom_cs_q, rom_cs_d;
    logic [3:0]      nib_q, nib_d;
    logic [3:0]      nib_att_q, nib_att_d;
    logic [1:0]      nib_ch_q, nib_ch_d;
    logic            nib_first_q, nib_first_d;
    logic            nib_valid_q, nib_valid_d;

    logic [1:0]      w_slot_nxt;
    logic [1:0]      w_idx;
    logic            w_load;
    logic            w_inc;
    logic            w_clr_first;
    logic [ROMW:0]   w_cur;
    logic [ROMW-1:0] w_last;
    logic [3:0]      w_att;
    logic            w_first;

    assign w_slot_nxt = next_slot(slot_q);
    // Loads happen on slot entry (new slot); fetches work on the current slot
    assign w_idx      = cen4 ? w_slot_nxt : slot_q;

    jt6295_chseq_regs #(
        .ROMW (ROMW)
    ) u_regs (
        .rst          (rst),
        .clk          (clk),
        .idx_i        (w_idx),
        .load_i       (w_load),
        .start_addr_i (start_addr),
        .stop_addr_i  (stop_addr),
        .att_i        (att),
        .inc_i        (w_inc),
        .clr_first_i  (w_clr_first),
        .cur_o        (w_cur),
        .last_o       (w_last),
        .att_o        (w_att),
        .first_o      (w_first)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        busy_d      = busy_q;
        ack_d       = '0;
        zero_d      = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_cs_d    = rom_cs_q;
        nib_d       = nib_q;
        nib_att_d   = nib_att_q;
        nib_ch_d    = nib_ch_q;
        nib_first_d = nib_first_q;
        nib_valid_d = 1'b0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_clr_first = 1'b0;

        if (cen4) begin
            // Slot entry overrides any fetch still in flight
            slot_d   = w_slot_nxt;
            zero_d   = (w_slot_nxt == 2'd0);
            rom_cs_d = 1'b0;
            if (stop[w_slot_nxt]) begin
                busy_d[w_slot_nxt] = 1'b0;
            end else if (start[w_slot_nxt]) begin
                ack_d[w_slot_nxt] = 1'b1;
                if (!busy_q[w_slot_nxt]) begin
                    busy_d[w_slot_nxt] = 1'b1;
                    w_load             = 1'b1;
                end
            end
            state_d = busy_d[w_slot_nxt] ? ST_REQ : ST_IDLE;
        end else begin
            case (state_q)
                ST_REQ: begin
                    rom_addr_d = w_cur[ROMW:1];
                    rom_cs_d   = 1'b1;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_ok) begin
                        nib_d       = w_cur[0] ? rom_data[3:0] : rom_data[7:4];
                        nib_att_d   = w_att;
                        nib_ch_d    = slot_q;
                        nib_first_d = w_first;
                        nib_valid_d = 1'b1;
                        rom_cs_d    = 1'b0;
                        w_clr_first = 1'b1;
                        if (w_cur == {w_last, 1'b1})
                            busy_d[slot_q] = 1'b0;
                        else
                            w_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= 2'd3;
            busy_q      <= '0;
            ack_q       <= '0;
            zero_q      <= 1'b0;
            rom_addr_q  <= '0;
            rom_cs_q    <= 1'b0;
            nib_q       <= '0;
            nib_att_q   <= '0;
            nib_ch_q    <= '0;
            nib_first_q <= 1'b0;
            nib_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            zero_q      <= zero_d;
            rom_addr_q  <= rom_addr_d;
            rom_cs_q    <= rom_cs_d;
            nib_q       <= nib_d;
            nib_att_q   <= nib_att_d;
            nib_ch_q    <= nib_ch_d;
            nib_first_q <= nib_first_d;
            nib_valid_q <= nib_valid_d;
        end
    end

    assign busy      = busy_q;
    assign ack       = ack_q;
    assign zero      = zero_q;
    assign rom_addr  = rom_addr_q;
    assign rom_cs    = rom_cs_q;
    assign nib       = nib_q;
    assign nib_att   = nib_att_q;
    assign nib_ch    = nib_ch_q;
    assign nib_first = nib_first_q;
    assign nib_valid = nib_valid_q;

endmodule

`default_nettype wire
